// File: rtl/pc_ctrl.sv
// Program-counter sequencer: IDLE/RUN/HALT FSM driving the PC absolute-load path.
// Define PC_CTRL_STACK_EN to build the call/return stack with overflow/underflow detection.
module pc_ctrl #(
  parameter int unsigned D     = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt_req,
  input  logic         jump_req,
  input  logic         br_taken,
  input  logic         call_req,
  input  logic         ret_req,
  input  logic [7:0]   lut_idx,
  input  logic [D-1:0] prog_ctr,
  input  logic [D-1:0] lut_target,
  output logic [7:0]   lut_addr,
  output logic         absjump_en,
  output logic [D-1:0] target,
  output logic         running,
  output logic         done,
  output logic         stack_err
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e state_q, state_d;

  assign lut_addr = lut_idx;

`ifdef PC_CTRL_STACK_EN
  localparam int unsigned AW = $clog2(DEPTH) + 1;

  logic [AW-1:0] cnt_q, cnt_d;
  logic [D-1:0]  mem_q [DEPTH];
  logic          err_q, err_d;
  logic          push;
  logic          full, empty;
  logic [AW-2:0] top_idx;
  logic [D-1:0]  top;

  assign full    = (cnt_q == AW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_idx = cnt_q[AW-2:0] - (AW-1)'(1);
  assign top     = mem_q[top_idx];
`endif

  always_comb begin
    state_d    = state_q;
    absjump_en = 1'b1;
    target     = '0;
    running    = 1'b0;
    done       = 1'b0;
`ifdef PC_CTRL_STACK_EN
    push       = 1'b0;
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      HALT: begin
        done   = 1'b1;
        target = prog_ctr;
        if (start) state_d = RUN;
      end
      RUN: begin
        running = 1'b1;
        target  = lut_target;
        if (halt_req) begin
          target  = prog_ctr;
          state_d = HALT;
        end else if (ret_req) begin
`ifdef PC_CTRL_STACK_EN
          if (empty) begin
            target  = prog_ctr;
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            target = top;
            cnt_d  = cnt_q - AW'(1);
          end
`else
          // Return is a no-op without the stack, but still outranks call.
          absjump_en = 1'b0;
`endif
        end else if (call_req) begin
`ifdef PC_CTRL_STACK_EN
          if (full) begin
            target  = prog_ctr;
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            push  = 1'b1;
            cnt_d = cnt_q + AW'(1);
          end
`endif
        end else if (!(jump_req || br_taken)) begin
          absjump_en = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef PC_CTRL_STACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry contents need no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[cnt_q[AW-2:0]] <= prog_ctr + D'(1);
  end

  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: the bench owns the PC register and LUT, and checks every cycle
// against a queue-based reference model; directed scenarios then randomized traffic.
module tb_pc_ctrl;
  localparam int unsigned D     = 12;
  localparam int unsigned DEPTH = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic         clk = 1'b0;
  logic         reset, start, halt_req, jump_req, br_taken, call_req, ret_req;
  logic [7:0]   lut_idx, lut_addr;
  logic [D-1:0] pc, lut_target, target;
  logic         absjump_en, running, done, stack_err;

  int n_vec = 0;
  int n_mis = 0;

  int           m_mode, nx, act;
  logic [D-1:0] m_pc;
  logic [D-1:0] m_stk[$];
  bit           m_err;
  bit           e_aj, e_run, e_done, e_err;
  logic [D-1:0] e_t;
  logic         s_aj;
  logic [D-1:0] s_t, fz;

  always #5 clk = ~clk;

  function automatic logic [D-1:0] lut_f(input logic [7:0] a);
    if (a == 8'd0)  return D'(7);
    if (a == 8'd18) return D'(101);
    return D'(int'(a) * 37 + 5);
  endfunction

  assign lut_target = lut_f(lut_addr);

  pc_ctrl #(.D(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .jump_req(jump_req), .br_taken(br_taken), .call_req(call_req), .ret_req(ret_req),
    .lut_idx(lut_idx), .prog_ctr(pc), .lut_target(lut_target), .lut_addr(lut_addr),
    .absjump_en(absjump_en), .target(target), .running(running), .done(done),
    .stack_err(stack_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_err  = 1'b0;
    m_stk.delete();
  endtask

  // Expected combinational outputs and the pending effect of this cycle.
  task automatic model_out();
    e_aj = 1'b1; e_t = '0; e_run = 1'b0; e_done = 1'b0; nx = m_mode; act = 0;
    if (!reset) nx = M_IDLE;
    else if (m_mode == M_IDLE) begin
      if (start) nx = M_RUN;
    end else if (m_mode == M_HALT) begin
      e_done = 1'b1; e_t = m_pc;
      if (start) nx = M_RUN;
    end else begin
      e_run = 1'b1;
      if (halt_req) begin
        e_t = m_pc; nx = M_HALT;
      end else if (ret_req) begin
`ifdef PC_CTRL_STACK_EN
        if (m_stk.size() == 0) begin e_t = m_pc; nx = M_HALT; act = 3; end
        else begin e_t = m_stk[$]; act = 2; end
`else
        e_aj = 1'b0;
`endif
      end else if (call_req) begin
`ifdef PC_CTRL_STACK_EN
        if (m_stk.size() >= DEPTH) begin e_t = m_pc; nx = M_HALT; act = 3; end
        else begin e_t = lut_f(lut_idx); act = 1; end
`else
        e_t = lut_f(lut_idx);
`endif
      end else if (jump_req || br_taken) e_t = lut_f(lut_idx);
      else e_aj = 1'b0;
    end
    e_err = m_err;
  endtask

  task automatic model_next();
    case (act)
      1: m_stk.push_back(m_pc + D'(1));
      2: void'(m_stk.pop_back());
      3: m_err = 1'b1;
      default: ;
    endcase
    m_pc   = e_aj ? e_t : m_pc + D'(1);
    m_mode = nx;
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then advances one edge.
  task automatic step();
    #3;
    if (!reset) model_reset();
    model_out();
    chk("lut_addr", 32'(lut_addr), 32'(lut_idx));
    chk("absjump_en", 32'(absjump_en), 32'(e_aj));
    if (e_aj) chk("target", 32'(target), 32'(e_t));
    chk("running", 32'(running), 32'(e_run));
    chk("done", 32'(done), 32'(e_done));
    chk("stack_err", 32'(stack_err), 32'(e_err));
    chk("prog_ctr", 32'(pc), 32'(m_pc));
    s_aj = absjump_en;
    s_t  = target;
    @(posedge clk);
    #1;
    pc = s_aj ? s_t : pc + D'(1);
    model_next();
  endtask

  task automatic set_pc(input logic [D-1:0] v);
    pc   = v;
    m_pc = v;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; halt_req = 1'b0; jump_req = 1'b0; br_taken = 1'b0;
    call_req = 1'b0; ret_req = 1'b0; lut_idx = '0;
    pc = '0; m_pc = '0;
    model_reset();

    // Reset state
    step(); step();
    chk("rst_absjump", 32'(absjump_en), 32'd1);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_running", 32'(running), 32'd0);

    // Idle pins PC to 0, then run 10 cycles
    reset = 1'b1;
    repeat (5) step();
    chk("idle_pc", 32'(pc), 32'd0);
    chk("idle_running", 32'(running), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();
    chk("run_pc10", 32'(pc), 32'd10);
    chk("run_running", 32'(running), 32'd1);

    // Jump through LUT entry 0
    set_pc(D'(3));
    lut_idx = 8'd0; jump_req = 1'b1; step(); jump_req = 1'b0;
    chk("jump_pc", 32'(pc), 32'd7);
    step();
    chk("jump_pc_inc", 32'(pc), 32'd8);

    // Call / return
    set_pc(D'(20));
    lut_idx = 8'd18; call_req = 1'b1; step(); call_req = 1'b0;
    chk("call_pc", 32'(pc), 32'd101);
    repeat (3) step();
    chk("call_idle_pc", 32'(pc), 32'd104);
    ret_req = 1'b1; step(); ret_req = 1'b0;
`ifdef PC_CTRL_STACK_EN
    chk("ret_pc", 32'(pc), 32'd21);
`else
    chk("ret_ignored_pc", 32'(pc), 32'd105);
`endif

    // Nested calls past the stack depth
    for (int i = 0; i < 5; i++) begin
      lut_idx = 8'(40 + i); call_req = 1'b1; step();
    end
    call_req = 1'b0;
`ifdef PC_CTRL_STACK_EN
    chk("ovf_err", 32'(stack_err), 32'd1);
    chk("ovf_done", 32'(done), 32'd1);
    fz = pc;
    step(); step();
    chk("ovf_frozen", 32'(pc), 32'(fz));
`endif
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("resume_running", 32'(running), 32'd1);
`ifdef PC_CTRL_STACK_EN
    chk("err_sticky", 32'(stack_err), 32'd1);
`endif

    // Halt outranks branch; resume from held PC
    set_pc(D'(50));
    halt_req = 1'b1; br_taken = 1'b1; step(); halt_req = 1'b0; br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("halt_pc", 32'(pc), 32'd50);
      step();
    end
    chk("halt_pc_end", 32'(pc), 32'd50);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("resume_pc", 32'(pc), 32'd51);

    // Asynchronous reset between edges during a call
    lut_idx = 8'd5; call_req = 1'b1;
    #2; reset = 1'b0; #1;
    model_reset();
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_absjump", 32'(absjump_en), 32'd1);
    chk("arst_target", 32'(target), 32'd0);
    chk("arst_err", 32'(stack_err), 32'd0);
    step();
    call_req = 1'b0; reset = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    ret_req = 1'b1; step(); ret_req = 1'b0;
    step();
`ifdef PC_CTRL_STACK_EN
    chk("underflow_err", 32'(stack_err), 32'd1);
    chk("underflow_pc", 32'(pc), 32'd0);
`else
    chk("noret_pc", 32'(pc), 32'd2);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(99) != 0);
      start    = ($urandom_range(99) < 15);
      halt_req = ($urandom_range(99) < 4);
      ret_req  = ($urandom_range(99) < 12);
      call_req = ($urandom_range(99) < 12);
      jump_req = ($urandom_range(99) < 10);
      br_taken = ($urandom_range(99) < 10);
      lut_idx  = 8'($urandom_range(255));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter D, default 12, sets the program-counter width in bits.
REQ-002 Parameter DEPTH, default 4, sets the return-stack depth in entries (power of 2, minimum 2).
REQ-003 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-low reset (reset=0 resets).
REQ-005 start  input  1  Leaves IDLE or HALT and enters RUN.
REQ-006 halt_req  input  1  Requests entry to HALT.
REQ-007 jump_req  input  1  Unconditional absolute jump to the LUT target.
REQ-008 br_taken  input  1  Conditional branch resolved taken; absolute jump to the LUT target.
REQ-009 call_req  input  1  Subroutine call: push the return address, then jump to the LUT target.
REQ-010 ret_req  input  1  Subroutine return: pop the stack and jump to the popped address.
REQ-011 lut_idx  input  8  Branch index from the decoder.
REQ-012 prog_ctr  input  D  Current PC value.
REQ-013 lut_target  input  D  Target returned by the PC LUT for lut_addr.
REQ-014 lut_addr  output  8  Index to the PC LUT; always equals lut_idx.
REQ-015 absjump_en  output  1  PC absolute-load enable.
REQ-016 target  output  D  PC load value.
REQ-017 running  output  1  High in RUN only.
REQ-018 done  output  1  High in HALT only.
REQ-019 stack_err  output  1  Sticky flag for stack overflow or underflow.

Function
REQ-020 FSM states are IDLE, RUN and HALT; absjump_en, target, running and done are combinational from the state and inputs, so the PC acts on the next rising edge.
REQ-021 IDLE: absjump_en=1 and target=0, so the PC is pinned to 0; start=1 moves the FSM to RUN on the next edge.
REQ-022 HALT: absjump_en=1 and target=prog_ctr, so the PC holds; start=1 moves the FSM to RUN and the PC resumes from the held value.
REQ-023 RUN: requests are resolved in the priority halt_req > ret_req > call_req > jump_req|br_taken; with no request, absjump_en=0 and the PC self-increments.
REQ-024 RUN + halt_req: outputs absjump_en=1, target=prog_ctr; the next state is HALT; the stack is unchanged.
REQ-025 RUN + jump_req or br_taken: outputs absjump_en=1, target=lut_target.
REQ-026 RUN + call_req with the stack not full: outputs absjump_en=1, target=lut_target; pushes (prog_ctr+1) mod 2^D.
REQ-027 RUN + ret_req with the stack not empty: outputs absjump_en=1, target=top of stack; pops that entry.
REQ-028 Call with the stack full (overflow), or return with the stack empty (underflow): absjump_en=1, target=prog_ctr; sets stack_err; next state is HALT; the stack is unchanged.
REQ-029 The stack pointer and occupancy count are ceil(log2(DEPTH))+1 bits wide; the stack holds exactly DEPTH entries; push and pop never occur in the same cycle.
REQ-030 A request input in IDLE or HALT has no effect.
REQ-031 start in RUN is ignored.
REQ-032 stack_err is cleared only by reset.

Reset
REQ-033 When reset=0, the block asynchronously enters IDLE, clears stack occupancy to 0 and clears stack_err; stack entry contents are don't-care.
REQ-034 Reset asserted mid-call or mid-return discards any pending push or pop.
REQ-035 Output values under reset: absjump_en=1, target=0, running=0, done=0, stack_err=0.

Configuration
REQ-036 With macro PC_CTRL_STACK_EN defined, the return stack and REQ-026 to REQ-028 are implemented.
REQ-037 Without PC_CTRL_STACK_EN, no stack storage is built; call_req behaves exactly as jump_req; ret_req is ignored, so the PC increments; stack_err is tied to 0.

Verification
REQ-038 Reset with reset=0, then release reset with start=0 for 5 cycles -> prog_ctr=0, running=0; after start=1 and 10 cycles -> prog_ctr=10, running=1.
REQ-039 In RUN at prog_ctr=3, lut_idx=0 with jump_req=1 for one cycle -> prog_ctr=7; then prog_ctr=8 one cycle later.
REQ-040 In RUN at prog_ctr=20, lut_idx=18 with call_req=1 -> prog_ctr=101; 3 idle cycles -> prog_ctr=104; ret_req=1 -> prog_ctr=21.
REQ-041 With DEPTH=4, issue 5 nested calls -> after the 5th, stack_err=1, done=1, prog_ctr frozen; start=1 -> RUN with stack_err still 1.
REQ-042 halt_req and br_taken both asserted at prog_ctr=50 -> HALT, prog_ctr=50 for 4 cycles; start=1 -> prog_ctr=51 on the following edge.
REQ-043 Drive reset low asynchronously, between edges, during a call cycle -> IDLE immediately, occupancy=0; a following ret_req in RUN -> underflow, stack_err=1 (with the macro) or PC increments (without it).
